// File: rtl/pulse_gen.sv
// pulse_gen: programmable periodic pulse generator.
//
// Produces a registered pulse train with a runtime-programmable period and
// high width, plus a one-cycle sync strobe at the start of every period.
// Configuration is double-buffered: a legal load writes the pending
// registers, and the active registers only take them at a period boundary.
// The generator runs only while clk_ok (clock-ready from the upstream clock
// conversion stage) is 1; dropping it aborts to IDLE on the next edge.
//
// Optional feature: define PULSE_GEN_BURST_EN to add a burst_len input
// (captured with load) and a done output. A nonzero burst length limits a
// run to that many periods; done pulses in the first IDLE cycle afterwards,
// and a new run needs en to drop and rise again.
//
// Output timing: pulse/sync/busy are registered from the current counter
// and state, so they trail the internal counter by one cycle. When the next
// state is IDLE (graceful stop, burst end, abort) they are forced to 0 on
// that same edge.

module pulse_gen #(
   parameter int CNT_W = 16
) (
   input  logic             inclk0,
   input  logic             areset_n,
   input  logic             clk_ok,
   input  logic             en,
   input  logic             load,
   input  logic [CNT_W-1:0] period,
   input  logic [CNT_W-1:0] width,
`ifdef PULSE_GEN_BURST_EN
   input  logic [CNT_W-1:0] burst_len,
   output logic             done,
`endif
   output logic             pulse,
   output logic             sync,
   output logic             busy,
   output logic             err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;

   // Pending (written by load) and active (used by the counter) configuration.
   logic [CNT_W-1:0] pend_period;
   logic [CNT_W-1:0] pend_width;
   logic [CNT_W-1:0] act_period;
   logic [CNT_W-1:0] act_width;
   logic             pend_new;
   logic             cfg_valid;

   // Phase counter within the current period.
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;

   logic             load_ok;    // load strobe with a legal period/width pair
   logic             active;     // state is RUN or DRAIN
   logic             wrap;       // last cycle of the current period
   logic             enter;      // IDLE -> RUN on this edge
   logic             stay;       // running now and still running after this edge
   logic             apply;      // active registers take the pending values
   logic             burst_end;  // final period of a bounded burst ends now
   logic             start_block;// re-entry blocked until en drops

   // Legality: period >= 2, 1 <= width < period. Only these values ever reach
   // the active registers, so the unsigned compares below cannot overflow.
   assign load_ok = load
                  && (period >= CNT_W'(2))
                  && (width != '0)
                  && (width < period);

   assign active = (state != IDLE);
   assign wrap   = (cnt == act_period - CNT_W'(1));

`ifdef PULSE_GEN_BURST_EN
   logic [CNT_W-1:0] pend_burst;
   logic [CNT_W-1:0] act_burst;
   logic [CNT_W-1:0] per_cnt;    // completed periods in the current run
   logic             hold;       // burst finished, waiting for en to drop

   assign burst_end   = active && wrap
                      && (act_burst != '0)
                      && (per_cnt == act_burst - CNT_W'(1));
   assign start_block = hold;
`else
   assign burst_end   = 1'b0;
   assign start_block = 1'b0;
`endif

   // Next-state logic: abort has priority, then burst end, then run control.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves
      // it unassigned; an unassigned path would infer a latch.
      state_next = state;
      if (!clk_ok) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (en && cfg_valid && !start_block) begin
                  state_next = RUN;
               end
            end
            RUN: begin
               if (burst_end) begin
                  state_next = IDLE;
               end else if (!en) begin
                  // Stopping exactly on the wrap means the period is already
                  // complete, so there is nothing left to drain.
                  state_next = wrap ? IDLE : DRAIN;
               end
            end
            DRAIN: begin
               if (burst_end) begin
                  state_next = IDLE;
               end else if (en) begin
                  state_next = RUN;
               end else if (wrap) begin
                  state_next = IDLE;
               end
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   assign enter    = (state == IDLE) && (state_next == RUN);
   assign stay     = active && (state_next != IDLE);
   assign apply    = enter || (stay && wrap && pend_new);
   assign cnt_next = (stay && !wrap) ? cnt + CNT_W'(1) : '0;

   // State register.
   always_ff @(posedge inclk0 or negedge areset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values, independent of block ordering.
      if (!areset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Pending/active configuration, load validation and sticky error.
   always_ff @(posedge inclk0 or negedge areset_n) begin
      if (!areset_n) begin
         pend_period <= '0;
         pend_width  <= '0;
         act_period  <= '0;
         act_width   <= '0;
         pend_new    <= 1'b0;
         cfg_valid   <= 1'b0;
         err         <= 1'b0;
      end else begin
         if (load) begin
            if (load_ok) begin
               pend_period <= period;
               pend_width  <= width;
               cfg_valid   <= 1'b1;
               err         <= 1'b0;
            end else begin
               err <= 1'b1;
            end
         end

         // A load coinciding with a boundary update: the boundary consumes
         // the old pending values (read pre-edge), and the new load stays
         // pending for the following boundary.
         if (apply) begin
            act_period <= pend_period;
            act_width  <= pend_width;
         end

         if (load_ok) begin
            pend_new <= 1'b1;
         end else if (apply) begin
            pend_new <= 1'b0;
         end
      end
   end

   // Phase counter: counts while running, zero otherwise.
   always_ff @(posedge inclk0 or negedge areset_n) begin
      if (!areset_n) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_next;
      end
   end

   // Registered outputs, forced low on any edge that lands in IDLE.
   always_ff @(posedge inclk0 or negedge areset_n) begin
      if (!areset_n) begin
         pulse <= 1'b0;
         sync  <= 1'b0;
         busy  <= 1'b0;
      end else begin
         pulse <= stay && (cnt < act_width);
         sync  <= stay && (cnt == '0);
         busy  <= stay;
      end
   end

`ifdef PULSE_GEN_BURST_EN
   // Burst length capture, period counting, done strobe and re-entry hold.
   always_ff @(posedge inclk0 or negedge areset_n) begin
      if (!areset_n) begin
         pend_burst <= '0;
         act_burst  <= '0;
         per_cnt    <= '0;
         done       <= 1'b0;
         hold       <= 1'b0;
      end else begin
         if (load_ok) begin
            pend_burst <= burst_len;
         end

         if (enter) begin
            act_burst <= pend_burst;
            per_cnt   <= '0;
         end else if (stay && wrap) begin
            per_cnt <= per_cnt + CNT_W'(1);
         end

         // An abort is not a burst completion, so done needs clk_ok.
         done <= burst_end && clk_ok;

         if (burst_end && clk_ok) begin
            hold <= 1'b1;
         end else if (!en) begin
            hold <= 1'b0;
         end
      end
   end
`endif

endmodule

// File: tb/tb_pulse_gen.sv
// tb_pulse_gen: scoreboard bench for pulse_gen.
// Each queue entry holds the inputs to drive before one clock edge and the
// outputs required just after that edge. Expected outputs come from a small
// per-cycle description of the pulse pattern (index i in a period of width w
// gives pulse = i < w, sync = i == 0). Build with PULSE_GEN_BURST_EN defined
// to also cover the burst feature.

module tb_pulse_gen;

   localparam int CNT_W = 16;

   logic             inclk0 = 1'b0;
   logic             areset_n;
   logic             clk_ok;
   logic             en;
   logic             load;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] width;
   logic             pulse;
   logic             sync;
   logic             busy;
   logic             err;
   logic             done_w;
`ifdef PULSE_GEN_BURST_EN
   logic [CNT_W-1:0] burst_len;
`endif

   typedef struct packed {
      logic             clk_ok;
      logic             en;
      logic             load;
      logic [CNT_W-1:0] period;
      logic [CNT_W-1:0] width;
      logic [CNT_W-1:0] burst;
   } stim_t;

   typedef struct packed {
      logic pulse;
      logic sync;
      logic busy;
      logic err;
      logic done;
   } obs_t;

   typedef struct packed {
      stim_t s;
      obs_t  e;
   } item_t;

   item_t sb_q[$];
   stim_t cur;
   int    total = 0;
   int    bad   = 0;

   pulse_gen #(.CNT_W(CNT_W)) dut (
      .inclk0   (inclk0),
      .areset_n (areset_n),
      .clk_ok   (clk_ok),
      .en       (en),
      .load     (load),
      .period   (period),
      .width    (width),
`ifdef PULSE_GEN_BURST_EN
      .burst_len(burst_len),
      .done     (done_w),
`endif
      .pulse    (pulse),
      .sync     (sync),
      .busy     (busy),
      .err      (err)
   );

`ifndef PULSE_GEN_BURST_EN
   assign done_w = 1'b0;
`endif

   always #5 inclk0 = ~inclk0;

   // Outputs expected while not running.
   function automatic obs_t idle_o(input logic e, input logic d);
      obs_t o;
      o.pulse = 1'b0;
      o.sync  = 1'b0;
      o.busy  = 1'b0;
      o.err   = e;
      o.done  = d;
      return o;
   endfunction

   // Outputs expected at index i of a running period with high width w.
   function automatic obs_t run_o(input int w, input int i, input logic e);
      obs_t o;
      o.pulse = (i < w);
      o.sync  = (i == 0);
      o.busy  = 1'b1;
      o.err   = e;
      o.done  = 1'b0;
      return o;
   endfunction

   function automatic obs_t sample();
      obs_t o;
      o.pulse = pulse;
      o.sync  = sync;
      o.busy  = busy;
      o.err   = err;
      o.done  = done_w;
      return o;
   endfunction

   task automatic push(input obs_t e);
      item_t it;
      it.s      = cur;
      it.s.load = 1'b0;
      it.e      = e;
      sb_q.push_back(it);
   endtask

   task automatic push_load(input int p, input int w, input int b, input obs_t e);
      item_t it;
      it.s        = cur;
      it.s.load   = 1'b1;
      it.s.period = CNT_W'(p);
      it.s.width  = CNT_W'(w);
      it.s.burst  = CNT_W'(b);
      it.e        = e;
      sb_q.push_back(it);
   endtask

   // Indices from..to of a running period with high width w.
   task automatic push_span(input int w, input int from, input int to, input logic e);
      for (int i = from; i <= to; i++) begin
         push(run_o(w, i, e));
      end
   endtask

   task automatic apply(input stim_t s);
      clk_ok = s.clk_ok;
      en     = s.en;
      load   = s.load;
      period = s.period;
      width  = s.width;
`ifdef PULSE_GEN_BURST_EN
      burst_len = s.burst;
`endif
   endtask

   task automatic tick();
      @(posedge inclk0);
      #1;
   endtask

   task automatic test_reset();
      item_t it;
      obs_t  got;
      int    k;
      cur        = '0;
      cur.clk_ok = 1'b1;
      areset_n   = 1'b0;
      push(idle_o(1'b0, 1'b0));
      push(idle_o(1'b0, 1'b0));
      k = 0;
      while (sb_q.size() != 0) begin
         it = sb_q.pop_front();
         apply(it.s);
         tick();
         got = sample();
         total++;
         if (got !== it.e) begin
            bad++;
            $display("FAIL reset step %0d: got pulse,sync,busy,err,done=%b required %b", k, got, it.e);
         end
         k++;
      end
      // Out of reset with en=1 but no configuration loaded: must stay idle.
      areset_n = 1'b1;
      cur.en   = 1'b1;
      push(idle_o(1'b0, 1'b0));
      push(idle_o(1'b0, 1'b0));
      push(idle_o(1'b0, 1'b0));
      k = 0;
      while (sb_q.size() != 0) begin
         it = sb_q.pop_front();
         apply(it.s);
         tick();
         got = sample();
         total++;
         if (got !== it.e) begin
            bad++;
            $display("FAIL no_cfg step %0d: got pulse,sync,busy,err,done=%b required %b", k, got, it.e);
         end
         k++;
      end
      cur.en = 1'b0;
   endtask

   task automatic test_free_run();
      item_t it;
      obs_t  got;
      int    k;
      push_load(5, 2, 0, idle_o(1'b0, 1'b0));
      cur.en = 1'b1;
      push(idle_o(1'b0, 1'b0));          // edge that enters RUN
      for (int n = 0; n < 3; n++) begin
         push_span(2, 0, 4, 1'b0);
      end
      k = 0;
      while (sb_q.size() != 0) begin
         it = sb_q.pop_front();
         apply(it.s);
         tick();
         got = sample();
         total++;
         if (got !== it.e) begin
            bad++;
            $display("FAIL free_run step %0d: got pulse,sync,busy,err,done=%b required %b", k, got, it.e);
         end
         k++;
      end
   endtask

   task automatic test_illegal_load();
      item_t it;
      obs_t  got;
      int    k;
      push_load(4, 4, 0, run_o(2, 0, 1'b1));
      push_span(2, 1, 4, 1'b1);
      push_span(2, 0, 4, 1'b1);
      push_load(4, 1, 0, run_o(2, 0, 1'b0));
      push_span(2, 1, 4, 1'b0);
      push_span(1, 0, 3, 1'b0);
      k = 0;
      while (sb_q.size() != 0) begin
         it = sb_q.pop_front();
         apply(it.s);
         tick();
         got = sample();
         total++;
         if (got !== it.e) begin
            bad++;
            $display("FAIL illegal_load step %0d: got pulse,sync,busy,err,done=%b required %b", k, got, it.e);
         end
         k++;
      end
   endtask

   task automatic test_boundary_update();
      item_t it;
      obs_t  got;
      int    k;
      push_load(5, 2, 0, run_o(1, 0, 1'b0));  // 4/1 finishes, then 5/2
      push_span(1, 1, 3, 1'b0);
      push_span(2, 0, 1, 1'b0);
      push_load(8, 3, 0, run_o(2, 2, 1'b0));  // mid-period of 5/2
      push_span(2, 3, 4, 1'b0);
      push_span(3, 0, 0, 1'b0);
      push_load(6, 4, 0, run_o(3, 1, 1'b0));
      push_span(3, 2, 6, 1'b0);
      push_load(3, 1, 0, run_o(3, 7, 1'b0));  // load on the wrap edge
      push_span(4, 0, 5, 1'b0);               // wrap used the older 6/4
      push_span(1, 0, 2, 1'b0);               // then 3/1
      k = 0;
      while (sb_q.size() != 0) begin
         it = sb_q.pop_front();
         apply(it.s);
         tick();
         got = sample();
         total++;
         if (got !== it.e) begin
            bad++;
            $display("FAIL boundary_update step %0d: got pulse,sync,busy,err,done=%b required %b", k, got, it.e);
         end
         k++;
      end
   endtask

   task automatic test_graceful_stop();
      item_t it;
      obs_t  got;
      int    k;
      push_load(5, 2, 0, run_o(1, 0, 1'b0));
      push_span(1, 1, 2, 1'b0);
      push_span(2, 0, 4, 1'b0);
      push_span(2, 0, 0, 1'b0);
      cur.en = 1'b0;                          // sampled at cnt=1
      push_span(2, 1, 3, 1'b0);
      push(idle_o(1'b0, 1'b0));
      push(idle_o(1'b0, 1'b0));
      push(idle_o(1'b0, 1'b0));
      k = 0;
      while (sb_q.size() != 0) begin
         it = sb_q.pop_front();
         apply(it.s);
         tick();
         got = sample();
         total++;
         if (got !== it.e) begin
            bad++;
            $display("FAIL graceful_stop step %0d: got pulse,sync,busy,err,done=%b required %b", k, got, it.e);
         end
         k++;
      end
   endtask

   task automatic test_back_to_back();
      item_t it;
      obs_t  got;
      int    k;
      cur.en = 1'b1;
      push(idle_o(1'b0, 1'b0));
      cur.en = 1'b0;                          // RUN -> DRAIN
      push_span(2, 0, 0, 1'b0);
      cur.en = 1'b1;                          // DRAIN -> RUN, no gap
      push_span(2, 1, 4, 1'b0);
      push_span(2, 0, 4, 1'b0);
      k = 0;
      while (sb_q.size() != 0) begin
         it = sb_q.pop_front();
         apply(it.s);
         tick();
         got = sample();
         total++;
         if (got !== it.e) begin
            bad++;
            $display("FAIL back_to_back step %0d: got pulse,sync,busy,err,done=%b required %b", k, got, it.e);
         end
         k++;
      end
   endtask

   task automatic test_abort();
      item_t it;
      obs_t  got;
      int    k;
      push_load(0, 0, 0, run_o(2, 0, 1'b1));  // illegal: err set, config kept
      cur.clk_ok = 1'b0;                      // mid-pulse
      push(idle_o(1'b1, 1'b0));
      push(idle_o(1'b1, 1'b0));
      cur.clk_ok = 1'b1;
      push(idle_o(1'b1, 1'b0));               // re-enter RUN
      push_span(2, 0, 4, 1'b1);
      k = 0;
      while (sb_q.size() != 0) begin
         it = sb_q.pop_front();
         apply(it.s);
         tick();
         got = sample();
         total++;
         if (got !== it.e) begin
            bad++;
            $display("FAIL abort step %0d: got pulse,sync,busy,err,done=%b required %b", k, got, it.e);
         end
         k++;
      end
   endtask

`ifdef PULSE_GEN_BURST_EN
   task automatic test_burst();
      item_t it;
      obs_t  got;
      int    k;
      cur.en = 1'b0;                          // drain the running 5/2
      push_span(2, 0, 3, 1'b1);
      push(idle_o(1'b1, 1'b0));
      push_load(4, 1, 3, idle_o(1'b0, 1'b0));
      cur.en = 1'b1;
      push(idle_o(1'b0, 1'b0));
      push_span(1, 0, 3, 1'b0);
      push_span(1, 0, 3, 1'b0);
      push_span(1, 0, 2, 1'b0);
      push(idle_o(1'b0, 1'b1));               // done in first IDLE cycle
      push(idle_o(1'b0, 1'b0));               // en still high: no restart
      push(idle_o(1'b0, 1'b0));
      cur.en = 1'b0;
      push(idle_o(1'b0, 1'b0));
      cur.en = 1'b1;
      push(idle_o(1'b0, 1'b0));
      push_span(1, 0, 3, 1'b0);
      k = 0;
      while (sb_q.size() != 0) begin
         it = sb_q.pop_front();
         apply(it.s);
         tick();
         got = sample();
         total++;
         if (got !== it.e) begin
            bad++;
            $display("FAIL burst step %0d: got pulse,sync,busy,err,done=%b required %b", k, got, it.e);
         end
         k++;
      end
   endtask
`endif

   task automatic test_async_reset();
      item_t it;
      obs_t  got;
      obs_t  req;
      int    k;
      tick();
      areset_n = 1'b0;                        // between edges
      #1;
      got = sample();
      req = idle_o(1'b0, 1'b0);
      total++;
      if (got !== req) begin
         bad++;
         $display("FAIL async_reset: got pulse,sync,busy,err,done=%b required %b", got, req);
      end
      areset_n   = 1'b1;
      cur.en     = 1'b1;
      cur.clk_ok = 1'b1;
      push(idle_o(1'b0, 1'b0));               // configuration was cleared
      push(idle_o(1'b0, 1'b0));
      push_load(5, 2, 0, idle_o(1'b0, 1'b0));
      push(idle_o(1'b0, 1'b0));
      push_span(2, 0, 4, 1'b0);
      k = 0;
      while (sb_q.size() != 0) begin
         it = sb_q.pop_front();
         apply(it.s);
         tick();
         got = sample();
         total++;
         if (got !== it.e) begin
            bad++;
            $display("FAIL post_reset step %0d: got pulse,sync,busy,err,done=%b required %b", k, got, it.e);
         end
         k++;
      end
   endtask

   initial begin
      areset_n = 1'b0;
      clk_ok   = 1'b0;
      en       = 1'b0;
      load     = 1'b0;
      period   = '0;
      width    = '0;
`ifdef PULSE_GEN_BURST_EN
      burst_len = '0;
`endif
      test_reset();
      test_free_run();
      test_illegal_load();
      test_boundary_update();
      test_graceful_stop();
      test_back_to_back();
      test_abort();
`ifdef PULSE_GEN_BURST_EN
      test_burst();
`endif
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pulse_gen.md
# pulse_gen

Programmable periodic pulse generator in the Generators chain. It sits directly downstream of the clock-conversion stage and uses that stage's clock-ready flag (`clk_ok`) as its run qualifier. It produces a registered pulse train with a runtime-programmable period and high width, plus a one-cycle `sync` strobe at the start of every period. Configuration is double-buffered, so new settings take effect only on a period boundary.

## Interface
- `CNT_W`, default 16: width of the period, width and phase counters.
- `inclk0`  in  1  system clock; all logic is on its rising edge.
- `areset_n`  in  1  asynchronous active-low reset.
- `clk_ok`  in  1  clock-ready flag from the clock-conversion stage; the generator runs only while it is 1.
- `en`  in  1  run request.
- `load`  in  1  one-cycle strobe; captures `period`/`width` into the pending registers.
- `period`  in  CNT_W  cycles per pulse period; legal range 2..2^CNT_W-1.
- `width`  in  CNT_W  high cycles per period; legal range 1..period-1.
- `pulse`  out  1  registered pulse output.
- `sync`  out  1  registered; high for one cycle in cycle 0 of every period.
- `busy`  out  1  registered; high in RUN.
- `err`  out  1  registered, sticky; set by the last rejected load.

## Operation
- Reset (asynchronous assert, synchronous release):
  - All outputs are 0.
  - State is IDLE.
  - Active and pending `period`/`width` are 0.
  - `cfg_valid` is 0 and `pend_new` is 0.
- Load validation:
  - An illegal load (`period` < 2, `width` == 0 or `width` >= `period`) sets `err` and leaves the pending registers unchanged.
  - A legal load writes the pending registers, sets `pend_new` and `cfg_valid`, and clears `err`.
- States: IDLE, RUN, DRAIN.
  - IDLE -> RUN when `en` & `clk_ok` & `cfg_valid` are all 1. On entry, the active registers take the pending values, `pend_new` clears and `cnt` is 0.
  - RUN:
    - `cnt` increments each cycle and wraps from active_period-1 to 0.
    - At each wrap, if `pend_new` is set, the active registers take the pending values and `pend_new` clears.
    - `pulse` is 1 while `cnt` < active_width.
    - `sync` is 1 when `cnt` == 0.
  - RUN -> DRAIN when `en` is sampled 0. The current period completes normally.
  - DRAIN -> IDLE at the wrap point, with `pulse`, `sync` and `busy` all 0. If `en` returns to 1 during DRAIN, the state goes back to RUN with no gap.
  - Abort: `clk_ok` == 0 in any state forces IDLE on the next edge. `pulse`, `sync`, `busy` and `cnt` clear. `err`, pending and active registers are kept.
- Simultaneous `load` and wrap: the wrap uses the old pending values. The new load becomes pending for the next boundary.
- Counter arithmetic is CNT_W bits and unsigned. Comparisons are unsigned and never overflow, because only legal values ever reach the active registers.

## Timing
- Start latency: `en` sampled 1 at edge N (with `clk_ok` and `cfg_valid` both 1) gives `busy`, `sync` and `pulse` = 1 after edge N+1.
- Output `pulse` cycle sequence: 1 for active_width cycles, then 0 for period-width cycles, repeating.
- Config latency: a legal load at edge N takes effect at the first wrap after N+1. Within any single period the pulse shape never changes.
- `err` updates one cycle after `load`.
- Abort latency: `clk_ok` sampled 0 at edge N gives all of `pulse`, `sync` and `busy` = 0 after edge N.

## Configuration
- Macro `PULSE_GEN_BURST_EN`.
- When defined, the block adds:
  - input `burst_len` [CNT_W-1:0], captured with `load`;
  - output `done`.
- Burst behaviour with the macro defined:
  - A nonzero `burst_len` limits RUN to that many periods, after which the state returns to IDLE.
  - `done` pulses for one cycle in the first IDLE cycle.
  - `burst_len` == 0 means free-running.
  - Re-entry needs `en` to deassert and then reassert.
- When undefined: there are no extra ports and the block always free-runs.

## Test plan
- Free-run: load `period`=5, `width`=2, then `en`=1. Required: `pulse` = 1,1,0,0,0 repeating, and `sync` every 5th cycle aligned with the first 1.
- Illegal load: load `period`=4/`width`=4 while running 5/2. Required: `err`=1 and the 5/2 pattern continues. A following legal load of 4/1 clears `err`.
- Boundary update: load 8/3 mid-period of 5/2. Required: the current period ends as 5/2, then 8/3 starts at the next `sync`.
- Graceful stop: drop `en` at `cnt`=1. Required: the period finishes (3 more cycles) and then `busy`=0.
- Abort: drop `clk_ok` mid-pulse. Required: `pulse`/`busy`=0 after the next edge. Restoring `clk_ok` with `en`=1 restarts at `cnt`=0.
- Burst (macro on): `burst_len`=3 with 4/1. Required: exactly 3 pulses, `done` high for 1 cycle, then IDLE.
